rtc_bus_writer: RTL and testbench

//  Downstream stage of the user-edit FSM: executes one multiplexed-AD write cycle to the RTC chip.

---
 rtl/rtc_bus_writer_pkg.sv | 40 ++++
 rtl/rtc_phase_timer.sv | 28 ++
 rtl/rtc_bus_writer.sv | 189 ++++++++++++++++++
 tb/tb_rtc_bus_writer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_writer_pkg.sv
// Shared definitions for the RTC bus blocks.
//   - state_t      : write-side FSM state encoding
//   - T_*_DEF      : default bus timing in clk cycles
//   - ADDR_*       : RTC register address map; ADDR_NOP marks an edit slot with no register
//   - phase_load() : timer load value for a phase lasting t cycles
package rtc_bus_writer_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        A_SET   = 4'd1,
        A_WR    = 4'd2,
        A_HLD   = 4'd3,
        D_SET   = 4'd4,
        D_WR    = 4'd5,
        D_HLD   = 4'd6,
        DONE    = 4'd7,
        RELEASE = 4'd8
    } state_t;

    localparam int unsigned T_SETUP_DEF = 2;
    localparam int unsigned T_PULSE_DEF = 4;
    localparam int unsigned T_HOLD_DEF  = 2;

    localparam logic [7:0] ADDR_NOP       = 8'h00;
    localparam logic [7:0] ADDR_SEC       = 8'h21;
    localparam logic [7:0] ADDR_MIN       = 8'h22;
    localparam logic [7:0] ADDR_HR        = 8'h23;
    localparam logic [7:0] ADDR_DAY       = 8'h24;
    localparam logic [7:0] ADDR_MON       = 8'h25;
    localparam logic [7:0] ADDR_YR        = 8'h26;
    localparam logic [7:0] ADDR_TMR_SEC   = 8'h41;
    localparam logic [7:0] ADDR_TMR_MIN   = 8'h42;
    localparam logic [7:0] ADDR_TMR_HR    = 8'h43;

    // The timer counts down to zero inclusive, so a phase of t cycles loads t-1.
    function automatic logic [3:0] phase_load(input int unsigned t);
        return 4'(t - 1);
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable 4-bit down-counter with zero flag; paces bus phases.
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : value to load
//   zero       : count is 0 (counter holds at 0 until reloaded)
module rtc_phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/rtc_bus_writer.sv
// One multiplexed address/data write cycle to the RTC chip per request.
//   clk, reset : clock, synchronous active-high reset
//   escribe    : request level from the edit FSM, held until fin is seen
//   dir_out    : RTC register address (0x00 = no-op slot)
//   dato_out   : BCD data byte
//   fin        : one-cycle completion pulse
//   busy       : request accepted and not yet finished
//   rtc_cs_n, rtc_wr_n, rtc_rd_n, rtc_a_d, rtc_ad : RTC bus pins (all registered)
//   ad_oe      : enable for the rtc_ad pad driver
//
// state   | meaning
// IDLE    | waiting for escribe; captures address/data
// A_SET   | address on AD, a_d=0, before the WR strobe
// A_WR    | WR low for the address phase
// A_HLD   | address held after WR rises
// D_SET   | data on AD, a_d=1, before the WR strobe
// D_WR    | WR low for the data phase
// D_HLD   | data held after WR rises
// DONE    | fin pulse, bus released
// RELEASE | wait for escribe to drop so one request makes one write
module rtc_bus_writer
    import rtc_bus_writer_pkg::*;
#(
    parameter int unsigned T_SETUP = T_SETUP_DEF,
    parameter int unsigned T_PULSE = T_PULSE_DEF,
    parameter int unsigned T_HOLD  = T_HOLD_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       escribe,
    input  logic [7:0] dir_out,
    input  logic [7:0] dato_out,
    output logic       fin,
    output logic       busy,
    output logic       rtc_cs_n,
    output logic       rtc_wr_n,
    output logic       rtc_rd_n,
    output logic       rtc_a_d,
    output logic [7:0] rtc_ad,
    output logic       ad_oe
);

    localparam logic [3:0] LD_SETUP = phase_load(T_SETUP);
    localparam logic [3:0] LD_PULSE = phase_load(T_PULSE);
    localparam logic [3:0] LD_HOLD  = phase_load(T_HOLD);

    state_t     state;
    logic [7:0] data_q;
    logic       nop_q;
    logic       tmr_load;
    logic [3:0] tmr_val;
    logic       tmr_zero;

    // Reload the timer on every state entry with the length of the state being entered.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = 4'd0;
        case (state)
            IDLE: begin
                if (escribe && !nop_q && dir_out != ADDR_NOP) begin
                    tmr_load = 1'b1;
                    tmr_val  = LD_SETUP;
                end
            end
            A_SET, D_SET: begin
                tmr_load = tmr_zero;
                tmr_val  = LD_PULSE;
            end
            A_WR, D_WR: begin
                tmr_load = tmr_zero;
                tmr_val  = LD_HOLD;
            end
            A_HLD: begin
                tmr_load = tmr_zero;
                tmr_val  = LD_SETUP;
            end
            default: begin
                tmr_load = 1'b0;
                tmr_val  = 4'd0;
            end
        endcase
    end

    rtc_phase_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Bus pins change only on *_SET entry; wr_n moves alone on *_WR entry/exit,
    // so the strobe edge never coincides with an address/data/cs change.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            data_q   <= 8'd0;
            nop_q    <= 1'b0;
            fin      <= 1'b0;
            busy     <= 1'b0;
            rtc_cs_n <= 1'b1;
            rtc_wr_n <= 1'b1;
            rtc_rd_n <= 1'b1;
            rtc_a_d  <= 1'b0;
            rtc_ad   <= 8'd0;
            ad_oe    <= 1'b0;
        end else begin
            fin <= 1'b0;
            case (state)
                IDLE: begin
                    if (nop_q) begin
                        // No-op slot: one accepted cycle, then complete without touching the bus.
                        nop_q <= 1'b0;
                        state <= DONE;
                        fin   <= 1'b1;
                        busy  <= 1'b0;
                    end else if (escribe) begin
                        data_q <= dato_out;
                        busy   <= 1'b1;
                        if (dir_out == ADDR_NOP) begin
                            nop_q <= 1'b1;
                        end else begin
                            // rtc_ad itself holds the captured address for the address phase.
                            state    <= A_SET;
                            rtc_cs_n <= 1'b0;
                            rtc_a_d  <= 1'b0;
                            rtc_ad   <= dir_out;
                            ad_oe    <= 1'b1;
                        end
                    end
                end
                A_SET: begin
                    if (tmr_zero) begin
                        state    <= A_WR;
                        rtc_wr_n <= 1'b0;
                    end
                end
                A_WR: begin
                    if (tmr_zero) begin
                        state    <= A_HLD;
                        rtc_wr_n <= 1'b1;
                    end
                end
                A_HLD: begin
                    if (tmr_zero) begin
                        state   <= D_SET;
                        rtc_a_d <= 1'b1;
                        rtc_ad  <= data_q;
                    end
                end
                D_SET: begin
                    if (tmr_zero) begin
                        state    <= D_WR;
                        rtc_wr_n <= 1'b0;
                    end
                end
                D_WR: begin
                    if (tmr_zero) begin
                        state    <= D_HLD;
                        rtc_wr_n <= 1'b1;
                    end
                end
                D_HLD: begin
                    if (tmr_zero) begin
                        state    <= DONE;
                        fin      <= 1'b1;
                        busy     <= 1'b0;
                        rtc_cs_n <= 1'b1;
                        rtc_a_d  <= 1'b0;
                        rtc_ad   <= 8'd0;
                        ad_oe    <= 1'b0;
                    end
                end
                DONE: begin
                    state <= RELEASE;
                end
                RELEASE: begin
                    if (!escribe) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_bus_writer.sv
module tb_rtc_bus_writer;
    import rtc_bus_writer_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // index 0: default timing instance, index 1: 1/1/1 timing instance
    logic       reset[2];
    logic       escribe[2];
    logic [7:0] dir_out[2];
    logic [7:0] dato_out[2];
    logic       fin[2], busy[2], cs_n[2], wr_n[2], rd_n[2], a_d[2], ad_oe[2];
    logic [7:0] ad[2];

    rtc_bus_writer dut_def (
        .clk(clk), .reset(reset[0]), .escribe(escribe[0]), .dir_out(dir_out[0]),
        .dato_out(dato_out[0]), .fin(fin[0]), .busy(busy[0]), .rtc_cs_n(cs_n[0]),
        .rtc_wr_n(wr_n[0]), .rtc_rd_n(rd_n[0]), .rtc_a_d(a_d[0]), .rtc_ad(ad[0]),
        .ad_oe(ad_oe[0])
    );

    rtc_bus_writer #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1)) dut_fast (
        .clk(clk), .reset(reset[1]), .escribe(escribe[1]), .dir_out(dir_out[1]),
        .dato_out(dato_out[1]), .fin(fin[1]), .busy(busy[1]), .rtc_cs_n(cs_n[1]),
        .rtc_wr_n(wr_n[1]), .rtc_rd_n(rd_n[1]), .rtc_a_d(a_d[1]), .rtc_ad(ad[1]),
        .ad_oe(ad_oe[1])
    );

    typedef struct packed {
        logic       fin;
        logic       busy;
        logic       cs_n;
        logic       wr_n;
        logic       rd_n;
        logic       a_d;
        logic [7:0] ad;
        logic       ad_oe;
    } out_t;

    typedef struct {
        int         fast;
        logic [7:0] dir;
        logic [7:0] dato;
        int         hold;      // cycles escribe stays high after fin
        int         chg;       // 0 none, 1 dato+1 during A_WR, 2 scramble inputs each cycle
        int         exp_fin;   // cycle index (after E0) where fin is high
        int         exp_bytes; // bytes latched by the bus model
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    // Bus model: the RTC latches {a_d, ad} on the WR rising edge.
    logic [8:0] cap0[$];
    logic [8:0] cap1[$];
    logic [8:0] all1[$];
    always @(posedge wr_n[0]) cap0.push_back({a_d[0], ad[0]});
    always @(posedge wr_n[1]) begin
        cap1.push_back({a_d[1], ad[1]});
        all1.push_back({a_d[1], ad[1]});
    end

    function automatic out_t idle_out();
        out_t o;
        o.fin = 1'b0; o.busy = 1'b0; o.cs_n = 1'b1; o.wr_n = 1'b1;
        o.rd_n = 1'b1; o.a_d = 1'b0; o.ad = 8'h00; o.ad_oe = 1'b0;
        return o;
    endfunction

    // Expected pins in cycle c after the request edge E0.
    function automatic out_t model(int s, int p, int h, logic [7:0] dir, logic [7:0] dato, int c);
        out_t o = idle_out();
        int len = s + p + h;
        int off;
        if (c < 0) return o;
        if (dir == 8'h00) begin
            if (c == 0) o.busy = 1'b1;
            else if (c == 1) o.fin = 1'b1;
        end else if (c < 2 * len) begin
            o.busy  = 1'b1;
            o.cs_n  = 1'b0;
            o.ad_oe = 1'b1;
            o.a_d   = (c >= len);
            o.ad    = o.a_d ? dato : dir;
            off     = c % len;
            o.wr_n  = !(off >= s && off < s + p);
        end else if (c == 2 * len) begin
            o.fin = 1'b1;
        end
        return o;
    endfunction

    function automatic out_t actual(int i);
        out_t o;
        o.fin = fin[i]; o.busy = busy[i]; o.cs_n = cs_n[i]; o.wr_n = wr_n[i];
        o.rd_n = rd_n[i]; o.a_d = a_d[i]; o.ad = ad[i]; o.ad_oe = ad_oe[i];
        return o;
    endfunction

    task automatic check_out(input string name, input int c, input out_t got, input out_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: pins got=%h want=%h (fin,busy,cs_n,wr_n,rd_n,a_d,ad,oe)",
                     name, c, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got=%0d want=%0d", name, got, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int i = v.fast;
        int s = (i != 0) ? 1 : 2;
        int p = (i != 0) ? 1 : 4;
        int h = (i != 0) ? 1 : 2;
        int fc = (v.dir == 8'h00) ? 1 : 2 * (s + p + h);
        int drop = fc + v.hold;
        int fin_seen = -1;
        int fin_cnt = 0;
        logic [8:0] q[$];
        @(negedge clk);
        if (i == 0) cap0.delete(); else cap1.delete();
        dir_out[i]  = v.dir;
        dato_out[i] = v.dato;
        escribe[i]  = 1'b1;
        for (int c = 0; c <= drop + 3; c++) begin
            @(posedge clk); #1;
            check_out(tag, c, actual(i), model(s, p, h, v.dir, v.dato, c));
            if (fin[i] === 1'b1) begin
                fin_cnt++;
                if (fin_seen < 0) fin_seen = c;
            end
            @(negedge clk);
            if (c == drop) escribe[i] = 1'b0;
            if (v.chg == 1 && c == 2) dato_out[i] = v.dato + 8'd1;
            if (v.chg == 2) begin
                dir_out[i]  = 8'($urandom);
                dato_out[i] = 8'($urandom);
            end
        end
        check_int({tag, " fin_cycle"}, fin_seen, v.exp_fin);
        check_int({tag, " fin_count"}, fin_cnt, 1);
        q = (i != 0) ? cap1 : cap0;
        check_int({tag, " bytes"}, q.size(), v.exp_bytes);
        if (v.exp_bytes == 2 && q.size() == 2) begin
            check_int({tag, " addr_byte"}, int'(q[0]), int'({1'b0, v.dir}));
            check_int({tag, " data_byte"}, int'(q[1]), int'({1'b1, v.dato}));
        end
    endtask

    vec_t tbl[$];
    logic [7:0] slots[9];

    initial begin
        vec_t v;
        slots = '{ADDR_SEC, ADDR_MIN, ADDR_HR, ADDR_DAY, ADDR_MON, ADDR_YR,
                  ADDR_TMR_SEC, ADDR_TMR_MIN, ADDR_TMR_HR};
        tbl.push_back('{0, 8'h21, 8'h45, 0, 0, 16, 2});
        tbl.push_back('{0, 8'h21, 8'h45, 2, 0, 16, 2});
        tbl.push_back('{0, 8'h00, 8'h33, 1, 0,  1, 0});
        tbl.push_back('{0, 8'h22, 8'h45, 1, 1, 16, 2});
        tbl.push_back('{1, 8'h23, 8'h12, 0, 0,  6, 2});
        tbl.push_back('{1, 8'h00, 8'h00, 2, 0,  1, 0});
        tbl.push_back('{0, 8'h43, 8'h99, 1, 2, 16, 2});
        tbl.push_back('{1, 8'h41, 8'h59, 2, 1,  6, 2});

        for (int i = 0; i < 2; i++) begin
            reset[i] = 1'b1; escribe[i] = 1'b0; dir_out[i] = 8'h00; dato_out[i] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        check_out("reset_def", 0, actual(0), idle_out());
        check_out("reset_fast", 0, actual(1), idle_out());
        @(negedge clk);
        reset[0] = 1'b0;
        reset[1] = 1'b0;

        foreach (tbl[k]) run_vec(tbl[k], $sformatf("table%0d", k));

        // Reset during D_WR of the default instance, then a normal write.
        @(negedge clk);
        dir_out[0] = 8'h24; dato_out[0] = 8'h59; escribe[0] = 1'b1;
        for (int c = 0; c <= 11; c++) begin
            @(posedge clk); #1;
            check_out("pre_reset", c, actual(0), model(2, 4, 2, 8'h24, 8'h59, c));
            @(negedge clk);
        end
        reset[0] = 1'b1;
        escribe[0] = 1'b0;
        @(posedge clk); #1;
        check_out("reset_mid", 0, actual(0), idle_out());
        @(negedge clk);
        reset[0] = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            check_out("post_reset", c, actual(0), idle_out());
        end
        run_vec('{0, 8'h25, 8'h08, 1, 0, 16, 2}, "after_reset");

        // Nine edit slots back-to-back on the fast instance.
        all1.delete();
        for (int k = 0; k < 9; k++) begin
            v = '{1, slots[k], 8'(k * 7 + 1), int'($urandom_range(0, 2)), 2, 6, 2};
            run_vec(v, $sformatf("slot%0d", k));
        end
        check_int("slot_total_bytes", all1.size(), 18);
        if (all1.size() == 18) begin
            for (int k = 0; k < 9; k++) begin
                check_int($sformatf("slot%0d_bus_addr", k), int'(all1[2*k]), int'({1'b0, slots[k]}));
                check_int($sformatf("slot%0d_bus_data", k), int'(all1[2*k+1]),
                          int'({1'b1, 8'(k * 7 + 1)}));
            end
        end

        // Random requests against the model on both instances.
        for (int k = 0; k < 30; k++) begin
            v.fast = int'($urandom_range(0, 1));
            v.dir  = ($urandom_range(0, 4) == 0) ? 8'h00 : slots[$urandom_range(0, 8)];
            v.dato = 8'($urandom);
            v.hold = int'($urandom_range(0, 2));
            v.chg  = 2;
            v.exp_fin   = (v.dir == 8'h00) ? 1 : ((v.fast != 0) ? 6 : 16);
            v.exp_bytes = (v.dir == 8'h00) ? 0 : 2;
            run_vec(v, $sformatf("rand%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
